// File: rtl/mac_result_collector_if.sv
// rtl/mac_result_collector_if.sv - result stream port of the MAC result collector
interface mac_result_collector_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 2
);
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [IDX_W-1:0]  res_index;

  modport master (
    output res_valid,
    output res_data,
    output res_index,
    input  res_ready
  );

  modport slave (
    input  res_valid,
    input  res_data,
    input  res_index,
    output res_ready
  );
endinterface

// File: rtl/mac_result_collector.sv
// rtl/mac_result_collector.sv - splits a running MAC accumulator into dot-product results and queues them
module mac_result_collector #(
  parameter int DATA_W  = 16,
  parameter int DOT_LEN = 4,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      mac_out,
  mac_result_collector_if.master res,
  output logic                   full,
  output logic                   overflow,
  output logic                   frame_done
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DOT_LEN);
  localparam int OCC_W = IDX_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DOT_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

  typedef enum logic {
    ACCUM   = 1'b0,
    CAPTURE = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              capture;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] base_q;
  logic [IDX_W-1:0]  elem_idx_q;
  logic              overflow_q;
  logic              frame_done_q;

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [IDX_W-1:0]  idx_mem  [DEPTH];
  logic [IDX_W-1:0]  wr_ptr_q;
  logic [IDX_W-1:0]  rd_ptr_q;
  logic [OCC_W-1:0]  occ_q;

  logic              fifo_valid;
  logic              fifo_full;
  logic              pop;
  logic              push;
  logic [DATA_W-1:0] result;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // clear wins over a capture that would otherwise commit this cycle
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      ACCUM: begin
        if (in_valid && (cnt_q == CNT_LAST)) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        capture = 1'b1;
        state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
    if (clear) begin
      state_d = ACCUM;
      capture = 1'b0;
    end
  end

  assign fifo_valid = (occ_q != '0);
  assign fifo_full  = (occ_q == OCC_FULL);
  assign pop        = fifo_valid && res.res_ready && !clear;
  assign push       = capture && !(fifo_full && !pop);
  assign result     = mac_out - base_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q        <= '0;
      base_q       <= '0;
      elem_idx_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else if (clear) begin
      cnt_q        <= '0;
      base_q       <= '0;
      elem_idx_q   <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (in_valid) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end
      // base and index advance even when the result is dropped
      if (capture) begin
        base_q     <= mac_out;
        elem_idx_q <= elem_idx_q + 1'b1;
      end
      if (capture && !push) begin
        overflow_q <= 1'b1;
      end
      frame_done_q <= capture && (elem_idx_q == IDX_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= result;
      idx_mem[wr_ptr_q]  <= elem_idx_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // head is gated so an empty queue presents zeros rather than stale storage
  assign res.res_valid = fifo_valid;
  assign res.res_data  = fifo_valid ? data_mem[rd_ptr_q] : '0;
  assign res.res_index = fifo_valid ? idx_mem[rd_ptr_q] : '0;
  assign full          = fifo_full;
  assign overflow      = overflow_q;
  assign frame_done    = frame_done_q;

endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Receive-side companion to the operand sequencer that feeds the MAC. Watches the MAC's running accumulator output, splits it into completed dot products of `DOT_LEN` operand pairs, and buffers each result with its matrix-element index in a small FIFO drained through a valid/ready port. Results are recovered by differencing successive accumulator snapshots, so the MAC never needs to be cleared between dot products.

## Interface
- `DATA_W`, 16: width of the MAC accumulator and of each result.
- `DOT_LEN`, 4: operand pairs per dot product; must be at least 2.
- `DEPTH`, 4: FIFO entries and result elements per matrix (2x2 result); power of two.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `clear`  in  1  synchronous flush; asserted in the same cycle as the MAC's own clear.
- `in_valid`  in  1  one operand pair is presented to the MAC this cycle.
- `mac_out`  in  `DATA_W`  MAC accumulator output.
- `res_valid`  out  1  FIFO head is valid.
- `res_ready`  in  1  consumer accepts head when `res_valid` is also high.
- `res_data`  out  `DATA_W`  head result.
- `res_index`  out  log2(`DEPTH`)  matrix element index of head result.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `overflow`  out  1  sticky; a result was dropped because the FIFO was full.
- `frame_done`  out  1  one-cycle pulse when element `DEPTH`-1 of a matrix completes.

## Operation
- The MAC output at cycle t+1 includes the pair presented at cycle t.
- Pair counter `cnt` runs 0..`DOT_LEN`-1. It increments on each `in_valid` and wraps to 0 on the last pair.
- State machine:
  - ACCUM: counting pairs. When `in_valid` is high and `cnt`=`DOT_LEN`-1, go to CAPTURE.
  - CAPTURE: lasts one cycle, then returns to ACCUM.
- CAPTURE actions, all at the closing edge of the CAPTURE cycle:
  - `result = mac_out - base`, computed modulo 2^`DATA_W`.
  - `base` is loaded with `mac_out`.
  - `elem_idx` increments modulo `DEPTH`.
  - `{result, elem_idx}` is pushed into the FIFO unless the FIFO is full after this cycle's pop.
- Pairs arriving with `in_valid` during CAPTURE count toward the next dot product. Back-to-back streaming is therefore loss-free.
- Full FIFO at capture:
  - The result is dropped and `overflow` is set.
  - `base` and `elem_idx` still advance, so later indices stay aligned with matrix positions.
- Push and pop in the same cycle:
  - Both take effect.
  - A full FIFO with a simultaneous pop accepts the push.
- `frame_done` pulses in the cycle after a capture of `elem_idx`=`DEPTH`-1, whether that result was stored or dropped.
- `clear` has priority over capture, push and pop in the same cycle. It:
  - empties the FIFO;
  - zeroes `cnt`, `base`, `elem_idx` and `overflow`;
  - returns the state machine to ACCUM;
  - discards any in-flight capture.
- `reset` asserted mid-operation aborts everything. Behaviour after release is identical to `clear`.

## Timing
- Reset/clear values:
  - `res_valid` 0, `res_data` 0, `res_index` 0.
  - `full` 0, `overflow` 0, `frame_done` 0.
  - State ACCUM, `cnt`, `base` and `elem_idx` 0.
- The last pair of a dot product is presented at cycle t. The MAC output includes it at t+1 (CAPTURE). With a non-full FIFO, the result is visible at t+2:
  - `res_valid` is high at t+2 if the FIFO was empty.
  - Otherwise the result is queued behind earlier entries.
- FIFO is show-ahead: `res_data` and `res_index` reflect the head combinationally from registered storage.
- A pop occurs on an edge where `res_valid` and `res_ready` are both high. The next entry appears the following cycle.
- `full` and `res_valid` are registered status: they are updated on the same edge as the push or pop.
- `overflow` stays high until `clear` or `reset`.

## Test plan
- **Single dot product:** a=1,2,3,4 and b=4,5,6,7 with `in_valid` on 4 consecutive cycles, so `mac_out` reads 4, 14, 32, 60. Require `res_valid` 2 cycles after the last pair, `res_data`=60, `res_index`=0.
- **Back-to-back matrix:** 16 consecutive pairs, `mac_out` running from 60 to 120, 180 and 240, `res_ready`=1. Require 4 results all equal to 60 with indices 0,1,2,3, and one `frame_done` pulse after index 3.
- **Wrap-around:** `mac_out` jumps from 0xFFF0 before the dot product to 0x0010 after it. Require `res_data`=0x0020.
- **Overflow:** `res_ready`=0 for 5 dot products. Require `full`=1 after the fourth and `overflow`=1 after the fifth. On drain, require indices 0,1,2,3. The next stored result has index 1, since the dropped fifth result took index 0.
- **Simultaneous push and pop while full:** `res_ready`=1 in the capture-commit cycle. Require no overflow, `full` still 1, and the new entry at the tail.
- **Reset and clear mid-stream:**
  - Assert `reset` low after 2 pairs: all outputs go to 0 immediately, and a following 4-pair sequence yields 60 at index 0.
  - Repeat using `clear` together with the MAC clear: same result.
